// File: rtl/data_memory_param.sv
// Parametrised word-addressed data memory with a valid/ready request port, per-byte
// write enables, a one-cycle registered response, out-of-range errors and zero-fill after reset.
module data_memory_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough to hold DEPTH=65536 and any request address without truncation.
    localparam int CMP_W = ((ADDR_W > 17) ? ADDR_W : 17) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CMP_W-1:0] DEPTH_EXT = CMP_W'(DEPTH);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CMP_W-1:0]  addr_ext;
    logic              in_range;
    logic              accept;
    logic [IDX_W-1:0]  mem_idx;

    logic              vld_p1;
    logic              err_p1;
    logic [DATA_W-1:0] rdata_p1;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] result;
        result = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Request decode (stage 0)
    always_comb begin
        addr_ext = CMP_W'(req_addr);
        in_range = (addr_ext < DEPTH_EXT);
        mem_idx  = in_range ? addr_ext[IDX_W-1:0] : '0;
        accept   = req_valid && req_ready;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        req_ready  = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (fill_idx == LAST_IDX) begin
                    state_next = READY;
                end
            end
            READY: begin
                req_ready = 1'b1;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            fill_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                fill_idx <= (fill_idx == LAST_IDX) ? '0 : fill_idx + IDX_W'(1);
            end
        end
    end

    // Storage: zero-fill owns the array while clearing; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[fill_idx] <= '0;
        end else if (accept && req_we && in_range) begin
            mem[mem_idx] <= merge_lanes(mem[mem_idx], req_wdata, req_be);
        end
    end

    // Response register (stage 1); data is read-first relative to the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                err_p1   <= !in_range;
                rdata_p1 <= (!req_we && in_range) ? mem[mem_idx] : '0;
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_err   = err_p1;
    assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_data_memory_param.sv
// Self-checking bench for data_memory_param: a 16-bit x 8 instance driven by vector tables,
// hand sequences and random traffic against an array model, plus a 32-bit x 5 instance.
module tb_data_memory_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_we, req_ready;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;

    logic        b_valid, b_we, b_ready;
    logic [15:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    int num_checks = 0;
    int num_fail   = 0;

    logic [15:0] model16 [8];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    data_memory_param dut16 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    data_memory_param #(.DATA_W(32), .DEPTH(5), .ADDR_W(16)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input logic [15:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Reference model: word array, byte lanes selected by be, out-of-range ignored.
    task automatic model_write(input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        int a;
        a = int'(addr);
        if (a < 8) begin
            if (be[0]) model16[a][7:0]  = wdata[7:0];
            if (be[1]) model16[a][15:8] = wdata[15:8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model16[i] = 16'h0000;
    endtask

    // Called just after the active edge; leaves inputs idle after the accept edge.
    task automatic req16(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic req32(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    // Must be entered just after the last edge at which rst was sampled high.
    task automatic wait_fill(input string tag);
        int n16 = -1;
        int n32 = -1;
        for (int c = 1; c <= 64 && (n16 < 0 || n32 < 0); c++) begin
            @(posedge clk); #1;
            if (!busy && n16 < 0) n16 = c;
            if (!b_busy && n32 < 0) n32 = c;
        end
        check({tag, "_fill16_cycles"}, 32'(n16), 32'd8);
        check({tag, "_fill32_cycles"}, 32'(n32), 32'd5);
        check({tag, "_ready16"}, 32'(req_ready), 32'd1);
        model_clear();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [15:0] addr, wdata, exp_rd;
        logic [1:0]  be;
        logic        exp_err;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        model_clear();

        // Reset state and fill length
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        wait_fill("init");

        // Vector table, one idle cycle between requests
        for (int a = 0; a < 8; a++) add_vec(1'b0, 16'(a), 16'h0, 2'b00, 16'h0000, 1'b0);
        add_vec(1'b1, 16'd3,     16'hA5C3, 2'b11, 16'h0000, 1'b0);
        add_vec(1'b1, 16'd3,     16'h1200, 2'b10, 16'h0000, 1'b0);
        add_vec(1'b0, 16'd3,     16'h0000, 2'b00, 16'h12C3, 1'b0);
        add_vec(1'b0, 16'd8,     16'h0000, 2'b00, 16'h0000, 1'b1);
        add_vec(1'b0, 16'hFFFF,  16'h0000, 2'b00, 16'h0000, 1'b1);
        add_vec(1'b1, 16'd8,     16'hBEEF, 2'b11, 16'h0000, 1'b1);
        add_vec(1'b0, 16'd0,     16'h0000, 2'b00, 16'h0000, 1'b0);
        add_vec(1'b1, 16'd2,     16'hFFFF, 2'b00, 16'h0000, 1'b0);
        add_vec(1'b0, 16'd2,     16'h0000, 2'b00, 16'h0000, 1'b0);
        add_vec(1'b1, 16'd1,     16'hABCD, 2'b01, 16'h0000, 1'b0);
        add_vec(1'b0, 16'd1,     16'h0000, 2'b00, 16'h00CD, 1'b0);
        add_vec(1'b0, 16'h0108,  16'h0000, 2'b00, 16'h0000, 1'b1);

        foreach (vecs[i]) begin
            req16(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            if (vecs[i].we) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            check($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("vec%0d_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", i), 32'(rsp_valid), 32'd0);
            check($sformatf("vec%0d_hold_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_hold_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
        end

        // Back-to-back stream
        req16(1'b1, 16'd5, 16'h0055, 2'b11);
        model_write(16'd5, 16'h0055, 2'b11);
        check("b2b_w5_valid", 32'(rsp_valid), 32'd1);
        check("b2b_w5_rdata", 32'(rsp_rdata), 32'd0);
        req16(1'b0, 16'd5, 16'h0000, 2'b00);
        check("b2b_r5_valid", 32'(rsp_valid), 32'd1);
        check("b2b_r5_rdata", 32'(rsp_rdata), 32'h0055);
        req16(1'b0, 16'd4, 16'h0000, 2'b00);
        check("b2b_r4_valid", 32'(rsp_valid), 32'd1);
        check("b2b_r4_rdata", 32'(rsp_rdata), 32'h0000);
        @(posedge clk); #1;
        check("b2b_end_valid", 32'(rsp_valid), 32'd0);

        // Random traffic against the model, random idle gaps
        for (int n = 0; n < 300; n++) begin
            int r;
            we    = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 13);
            addr  = (r == 12) ? 16'hFFFF : (r == 13) ? 16'(8 + $urandom_range(0, 300)) : 16'(r);
            wdata = 16'($urandom);
            be    = 2'($urandom_range(0, 3));
            exp_err = (int'(addr) >= 8);
            exp_rd  = (we || exp_err) ? 16'h0000 : model16[int'(addr)];
            req16(we, addr, wdata, be);
            if (we) model_write(addr, wdata, be);
            check($sformatf("rnd%0d_valid", n), 32'(rsp_valid), 32'd1);
            check($sformatf("rnd%0d_rdata", n), 32'(rsp_rdata), 32'(exp_rd));
            check($sformatf("rnd%0d_err", n), 32'(rsp_err), 32'(exp_err));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                check($sformatf("rnd%0d_idle", n), 32'(rsp_valid), 32'd0);
            end
        end

        // 32-bit, 5-word instance: lane masking and range edge
        req32(1'b1, 16'd4, 32'hDEADBEEF, 4'b0101);
        check("w32_valid", 32'(b_rsp_valid), 32'd1);
        check("w32_err", 32'(b_rsp_err), 32'd0);
        req32(1'b0, 16'd4, 32'h0, 4'b0000);
        check("r32_a4_rdata", b_rsp_rdata, 32'h00AD00EF);
        check("r32_a4_err", 32'(b_rsp_err), 32'd0);
        req32(1'b0, 16'd5, 32'h0, 4'b0000);
        check("r32_a5_valid", 32'(b_rsp_valid), 32'd1);
        check("r32_a5_err", 32'(b_rsp_err), 32'd1);
        check("r32_a5_rdata", b_rsp_rdata, 32'h0);
        @(posedge clk); #1;
        check("r32_pulse", 32'(b_rsp_valid), 32'd0);

        // Reset in the middle of the fill restarts it
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midfill_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_fill("midfill");

        // Reset with a request presented drops its response and clears memory
        req16(1'b1, 16'd3, 16'h7777, 2'b11);
        req16(1'b0, 16'd3, 16'h0000, 2'b00);
        check("pre_rst_rdata", 32'(rsp_rdata), 32'h7777);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd3;
        rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("inflight_valid", 32'(rsp_valid), 32'd0);
        check("inflight_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        wait_fill("inflight");
        req16(1'b0, 16'd3, 16'h0000, 2'b00);
        check("refill_a3_valid", 32'(rsp_valid), 32'd1);
        check("refill_a3_rdata", 32'(rsp_rdata), 32'h0000);
        req32(1'b0, 16'd4, 32'h0, 4'b0000);
        check("refill32_a4_rdata", b_rsp_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
